// File: rtl/pkt_injector.sv
// Host-to-switch packet injector: Avalon-MM pushes into three drain FIFOs.
// Optional PKT_INJ_HEX_EN adds hex1..hex3 seven-segment capture outputs.
module pkt_injector #(
  parameter int DEPTH = 16,
  parameter int CW    = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       chipselect,
  input  logic       write,
  input  logic       read,
  input  logic [2:0] address,
  input  logic [7:0] writedata,
  output logic [7:0] readdata,
  output logic [7:0] out_data1,
  output logic [7:0] out_data2,
  output logic [7:0] out_data3,
  output logic       out_valid1,
  output logic       out_valid2,
  output logic       out_valid3,
  input  logic       in_ready1,
  input  logic       in_ready2,
  input  logic       in_ready3
`ifdef PKT_INJ_HEX_EN
  ,
  output logic [7:0] hex1,
  output logic [7:0] hex2,
  output logic [7:0] hex3
`endif
);

  localparam int PW = $clog2(DEPTH);

  logic [7:0]    r_mem [3][DEPTH];
  logic [PW-1:0] r_wp  [3];
  logic [PW-1:0] r_rp  [3];
  logic [CW-1:0] r_occ [3];
  logic          r_drain;
  logic [2:0]    r_ovf;
  logic [7:0]    r_rdata;

  logic       w_wr;
  logic       w_flush;
  logic [2:0] w_rdy;
  logic [2:0] w_vld;
  logic [2:0] w_full;
  logic [2:0] w_pop;
  logic [2:0] w_push;
  logic [2:0] w_acc;
  logic [2:0] w_ovf_set;
  logic [7:0] w_head [3];

  assign w_rdy = {in_ready3, in_ready2, in_ready1};

  always_comb begin
    w_wr      = chipselect && write;
    w_flush   = w_wr && (address == 3'd3) && writedata[1];
    w_vld     = '0;
    w_full    = '0;
    w_pop     = '0;
    w_push    = '0;
    w_acc     = '0;
    w_ovf_set = '0;
    for (int k = 0; k < 3; k++) begin
      w_head[k]    = r_mem[k][r_rp[k]];
      w_vld[k]     = r_drain && (r_occ[k] != '0);
      w_full[k]    = (r_occ[k] == CW'(DEPTH));
      w_pop[k]     = w_vld[k] && w_rdy[k];
      // idle code 0x00 is never queued
      w_push[k]    = w_wr && (address == 3'(k)) && (writedata != 8'd0);
      w_acc[k]     = w_push[k] && (!w_full[k] || w_pop[k]);
      w_ovf_set[k] = w_push[k] && w_full[k] && !w_pop[k];
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (w_acc[k]) r_mem[k][r_wp[k]] <= writedata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < 3; k++) begin
        r_wp[k]  <= '0;
        r_rp[k]  <= '0;
        r_occ[k] <= '0;
      end
      r_drain <= 1'b0;
      r_ovf   <= '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (w_flush) begin
          r_wp[k]  <= '0;
          r_rp[k]  <= '0;
          r_occ[k] <= '0;
        end else begin
          if (w_acc[k]) r_wp[k] <= r_wp[k] + PW'(1);
          if (w_pop[k]) r_rp[k] <= r_rp[k] + PW'(1);
          r_occ[k] <= r_occ[k] + CW'(w_acc[k]) - CW'(w_pop[k]);
        end
      end
      if (w_wr && address == 3'd3) r_drain <= writedata[0];
      if (w_wr && address == 3'd4)
        r_ovf <= (r_ovf & ~writedata[2:0]) | w_ovf_set;
      else
        r_ovf <= r_ovf | w_ovf_set;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rdata <= 8'd251;
    end else if (chipselect && read) begin
      unique case (address)
        3'd0:    r_rdata <= 8'(r_occ[0]);
        3'd1:    r_rdata <= 8'(r_occ[1]);
        3'd2:    r_rdata <= 8'(r_occ[2]);
        3'd3:    r_rdata <= {7'd0, r_drain};
        3'd4:    r_rdata <= {2'b00, w_full, r_ovf};
        default: r_rdata <= 8'd252;
      endcase
    end else begin
      r_rdata <= 8'd251;
    end
  end

  assign readdata   = r_rdata;
  assign out_valid1 = w_vld[0];
  assign out_valid2 = w_vld[1];
  assign out_valid3 = w_vld[2];
  assign out_data1  = w_vld[0] ? w_head[0] : 8'd0;
  assign out_data2  = w_vld[1] ? w_head[1] : 8'd0;
  assign out_data3  = w_vld[2] ? w_head[2] : 8'd0;

`ifdef PKT_INJ_HEX_EN
  logic [7:0] r_hex [3];

  function automatic logic [7:0] seg(input logic [1:0] v);
    unique case (v)
      2'd0: seg = 8'd63;
      2'd1: seg = 8'd6;
      2'd2: seg = 8'd91;
      default: seg = 8'd79;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < 3; k++) r_hex[k] <= '0;
    end else begin
      for (int k = 0; k < 3; k++)
        if (w_pop[k]) r_hex[k] <= seg(w_head[k][1:0]);
    end
  end

  assign hex1 = r_hex[0];
  assign hex2 = r_hex[1];
  assign hex3 = r_hex[2];
`endif

endmodule
